// File: rtl/exu_trap_pkg.sv
// Shared types and constants for the commit-stage trap controller.
// Holds the cause codes, FSM encoding, mtvec modes and the redirect-target helper.
package exu_trap_pkg;

  localparam logic [4:0] CAUSE_IFU_MISALGN = 5'd0;
  localparam logic [4:0] CAUSE_ILL         = 5'd2;
  localparam logic [4:0] CAUSE_BRK         = 5'd3;
  localparam logic [4:0] CAUSE_ECALL       = 5'd11;
  localparam logic [4:0] CAUSE_MSI         = 5'd3;
  localparam logic [4:0] CAUSE_MTI         = 5'd7;
  localparam logic [4:0] CAUSE_MEI         = 5'd11;

  localparam logic [1:0] MTVEC_DIRECT = 2'b00;
  localparam logic [1:0] MTVEC_VECT   = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_REDIR
  } state_e;

  typedef enum logic [1:0] {
    TVAL_ZERO,
    TVAL_PC,
    TVAL_INSTR
  } tval_sel_e;

  // Only interrupts are vectored; MODE 1x falls back to the direct base.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic [4:0]  code,
                                              input logic        irq,
                                              input logic        vect_en);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (vect_en && irq && (mtvec[1:0] == MTVEC_VECT)) begin
      return base + {25'd0, code, 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/exu_trap_ctrl_if.sv
// Commit, CSR and redirect signals between the pipeline and the trap controller.
// The slave modport is the trap controller's view; master is the surrounding pipeline.
interface exu_trap_ctrl_if;

  logic        cmt_vld;
  logic        cmt_rdy;
  logic [31:0] cmt_pc;
  logic [31:0] cmt_instr;
  logic        cmt_ifu_misalgn;
  logic        cmt_ill;
  logic        cmt_ebreak;
  logic        cmt_ecall;
  logic        cmt_mret;
  logic        lsu_busy;

  logic        csr_mstatus_mie;
  logic [2:0]  csr_mie;
  logic [2:0]  csr_mip;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;

  logic        trap_ena;
  logic        mret_ena;
  logic        epc_en;
  logic [31:0] epc_pc;
  logic        in_retr;
  logic        cause_wen;
  logic [31:0] cause_dat;
  logic        tval_wen;
  logic [31:0] tval_dat;

  logic        flush_req;
  logic        redir_vld;
  logic [31:0] redir_pc;
  logic        redir_rdy;

  modport master (
    output cmt_vld, cmt_pc, cmt_instr, cmt_ifu_misalgn, cmt_ill, cmt_ebreak,
           cmt_ecall, cmt_mret, lsu_busy, csr_mstatus_mie, csr_mie, csr_mip,
           csr_mtvec, csr_mepc, redir_rdy,
    input  cmt_rdy, trap_ena, mret_ena, epc_en, epc_pc, in_retr, cause_wen,
           cause_dat, tval_wen, tval_dat, flush_req, redir_vld, redir_pc
  );

  modport slave (
    input  cmt_vld, cmt_pc, cmt_instr, cmt_ifu_misalgn, cmt_ill, cmt_ebreak,
           cmt_ecall, cmt_mret, lsu_busy, csr_mstatus_mie, csr_mie, csr_mip,
           csr_mtvec, csr_mepc, redir_rdy,
    output cmt_rdy, trap_ena, mret_ena, epc_en, epc_pc, in_retr, cause_wen,
           cause_dat, tval_wen, tval_dat, flush_req, redir_vld, redir_pc
  );

endinterface

// File: rtl/exu_trap_prio.sv
// Combinational arbiter: pending interrupts beat exceptions, exceptions beat MRET.
// Produces the winning cause code, its interrupt bit and which value feeds mtval.
module exu_trap_prio
  import exu_trap_pkg::*;
(
  input  logic [2:0] irq_pend,   // {MEI,MTI,MSI}, already masked by MIE/mie
  input  logic       misalgn,
  input  logic       ill,
  input  logic       ebreak,
  input  logic       ecall,
  input  logic       mret,
  output logic       is_irq,
  output logic       is_exc,
  output logic       is_mret,
  output logic [4:0] code,
  output tval_sel_e  tval_sel
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the if-chain infers a latch.
    is_irq   = |irq_pend;
    is_exc   = 1'b0;
    is_mret  = 1'b0;
    code     = '0;
    tval_sel = TVAL_ZERO;

    if (irq_pend[2]) begin
      code = CAUSE_MEI;
    end else if (irq_pend[0]) begin
      code = CAUSE_MSI;
    end else if (irq_pend[1]) begin
      code = CAUSE_MTI;
    end else if (misalgn) begin
      is_exc   = 1'b1;
      code     = CAUSE_IFU_MISALGN;
      tval_sel = TVAL_PC;
    end else if (ill) begin
      is_exc   = 1'b1;
      code     = CAUSE_ILL;
      tval_sel = TVAL_INSTR;
    end else if (ebreak) begin
      is_exc   = 1'b1;
      code     = CAUSE_BRK;
      tval_sel = TVAL_PC;
    end else if (ecall) begin
      is_exc   = 1'b1;
      code     = CAUSE_ECALL;
    end else if (mret) begin
      is_mret  = 1'b1;
    end
  end

endmodule

// File: rtl/exu_trap_ctrl.sv
// Commit-stage trap controller: arbitrates interrupts/exceptions/MRET, strobes the CSR unit
// for one COMMIT cycle and then holds a redirect to fetch until it is accepted.
module exu_trap_ctrl
  import exu_trap_pkg::*;
#(
  parameter bit VECTORED_EN  = 1'b1,
  parameter bit LSU_DRAIN_EN = 1'b1
) (
  input logic            clk,
  input logic            rst,
  exu_trap_ctrl_if.slave bus
);

  logic [2:0]  irq_pend;
  logic        is_irq, is_exc, is_mret;
  logic [4:0]  pr_code;
  tval_sel_e   pr_tval_sel;

  state_e      state_q;
  logic        cmt_rdy_q;
  logic [31:0] pc_q, tval_q;
  logic [4:0]  code_q;
  logic        irq_q, mret_q;

  logic        trap_ena_q, mret_ena_q, epc_en_q, in_retr_q;
  logic        cause_wen_q, tval_wen_q, flush_q, redir_vld_q;
  logic [31:0] epc_pc_q, cause_dat_q, tval_dat_q, redir_pc_q;

  logic        accept, evt, drain_now, go_commit, in_idle;
  logic [31:0] live_tval, c_pc, c_tval, target_d;
  logic [4:0]  c_code;
  logic        c_irq, c_mret;

  assign irq_pend = {3{bus.csr_mstatus_mie}} & bus.csr_mie & bus.csr_mip;

  exu_trap_prio u_prio (
    .irq_pend (irq_pend),
    .misalgn  (bus.cmt_ifu_misalgn),
    .ill      (bus.cmt_ill),
    .ebreak   (bus.cmt_ebreak),
    .ecall    (bus.cmt_ecall),
    .mret     (bus.cmt_mret),
    .is_irq   (is_irq),
    .is_exc   (is_exc),
    .is_mret  (is_mret),
    .code     (pr_code),
    .tval_sel (pr_tval_sel)
  );

  always_comb begin
    live_tval = '0;
    case (pr_tval_sel)
      TVAL_PC:    live_tval = bus.cmt_pc;
      TVAL_INSTR: live_tval = bus.cmt_instr;
      default:    live_tval = '0;
    endcase
  end

  assign accept    = bus.cmt_vld & cmt_rdy_q;
  assign evt       = is_irq | is_exc | is_mret;
  assign drain_now = LSU_DRAIN_EN & bus.lsu_busy;
  assign in_idle   = (state_q == ST_IDLE);

  // Skipping DRAIN commits straight from the live commit bus; otherwise from the latched copy.
  assign c_pc   = in_idle ? bus.cmt_pc : pc_q;
  assign c_tval = in_idle ? live_tval  : tval_q;
  assign c_code = in_idle ? pr_code    : code_q;
  assign c_irq  = in_idle ? is_irq     : irq_q;
  assign c_mret = in_idle ? is_mret    : mret_q;

  assign go_commit = (in_idle && accept && evt && !drain_now) ||
                     ((state_q == ST_DRAIN) && !bus.lsu_busy);

  assign target_d = mret_q ? (bus.csr_mepc & 32'hFFFF_FFFE)
                           : trap_target(bus.csr_mtvec, code_q, irq_q, VECTORED_EN);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= ST_IDLE;
      cmt_rdy_q   <= 1'b0;
      pc_q        <= '0;
      tval_q      <= '0;
      code_q      <= '0;
      irq_q       <= 1'b0;
      mret_q      <= 1'b0;
      trap_ena_q  <= 1'b0;
      mret_ena_q  <= 1'b0;
      epc_en_q    <= 1'b0;
      in_retr_q   <= 1'b0;
      cause_wen_q <= 1'b0;
      tval_wen_q  <= 1'b0;
      flush_q     <= 1'b0;
      redir_vld_q <= 1'b0;
      epc_pc_q    <= '0;
      cause_dat_q <= '0;
      tval_dat_q  <= '0;
      redir_pc_q  <= '0;
    end else begin
      trap_ena_q  <= 1'b0;
      mret_ena_q  <= 1'b0;
      epc_en_q    <= 1'b0;
      in_retr_q   <= 1'b0;
      cause_wen_q <= 1'b0;
      tval_wen_q  <= 1'b0;
      flush_q     <= 1'b0;
      epc_pc_q    <= '0;
      cause_dat_q <= '0;
      tval_dat_q  <= '0;

      unique case (state_q)
        ST_IDLE: begin
          cmt_rdy_q <= !(accept && evt);
          if (accept && evt) begin
            pc_q    <= bus.cmt_pc;
            tval_q  <= live_tval;
            code_q  <= pr_code;
            irq_q   <= is_irq;
            mret_q  <= is_mret;
            flush_q <= 1'b1;
            state_q <= drain_now ? ST_DRAIN : ST_COMMIT;
          end else if (accept) begin
            in_retr_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!bus.lsu_busy) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          redir_vld_q <= 1'b1;
          redir_pc_q  <= target_d;
          state_q     <= ST_REDIR;
        end
        ST_REDIR: begin
          if (bus.redir_rdy) begin
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
            cmt_rdy_q   <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (go_commit) begin
        if (c_mret) begin
          mret_ena_q <= 1'b1;
          in_retr_q  <= 1'b1;
        end else begin
          trap_ena_q  <= 1'b1;
          epc_en_q    <= 1'b1;
          cause_wen_q <= 1'b1;
          tval_wen_q  <= 1'b1;
          epc_pc_q    <= c_pc;
          cause_dat_q <= {c_irq, 26'b0, c_code};
          tval_dat_q  <= c_tval;
        end
      end
    end
  end

  assign bus.cmt_rdy   = cmt_rdy_q;
  assign bus.trap_ena  = trap_ena_q;
  assign bus.mret_ena  = mret_ena_q;
  assign bus.epc_en    = epc_en_q;
  assign bus.epc_pc    = epc_pc_q;
  assign bus.in_retr   = in_retr_q;
  assign bus.cause_wen = cause_wen_q;
  assign bus.cause_dat = cause_dat_q;
  assign bus.tval_wen  = tval_wen_q;
  assign bus.tval_dat  = tval_dat_q;
  assign bus.flush_req = flush_q;
  assign bus.redir_vld = redir_vld_q;
  assign bus.redir_pc  = redir_pc_q;

endmodule

// File: tb/tb_exu_trap_ctrl.sv
// Directed bench for exu_trap_ctrl: hand-computed expectations for traps, interrupts,
// MRET with LSU drain, redirect back-pressure and reset in the middle of a trap.
module tb_exu_trap_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  exu_trap_ctrl_if bus ();

  exu_trap_ctrl #(.VECTORED_EN(1'b1), .LSU_DRAIN_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required summary before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // flags = {misalgn, ill, ebreak, ecall, mret}
  task automatic drive(input logic vld, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] flags);
    bus.cmt_vld         = vld;
    bus.cmt_pc          = pc;
    bus.cmt_instr       = instr;
    bus.cmt_ifu_misalgn = flags[4];
    bus.cmt_ill         = flags[3];
    bus.cmt_ebreak      = flags[2];
    bus.cmt_ecall       = flags[1];
    bus.cmt_mret        = flags[0];
  endtask

  // Trap with idle LSU and a ready fetch unit: COMMIT at T+1, REDIR at T+2, IDLE at T+3.
  task automatic run_trap(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [4:0] flags, input logic [31:0] exp_cause,
                          input logic [31:0] exp_tval, input logic [31:0] exp_redir);
    drive(1'b1, pc, instr, flags);
    check({tag, ".rdy_pre"}, bus.cmt_rdy, 1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'b0);
    check({tag, ".trap_ena"},  bus.trap_ena, 1);
    check({tag, ".epc_en"},    bus.epc_en, 1);
    check({tag, ".cause_wen"}, bus.cause_wen, 1);
    check({tag, ".tval_wen"},  bus.tval_wen, 1);
    check({tag, ".cause"},     bus.cause_dat, exp_cause);
    check({tag, ".epc_pc"},    bus.epc_pc, pc);
    check({tag, ".tval"},      bus.tval_dat, exp_tval);
    check({tag, ".in_retr1"},  bus.in_retr, 0);
    check({tag, ".mret_ena"},  bus.mret_ena, 0);
    check({tag, ".flush"},     bus.flush_req, 1);
    check({tag, ".rdy_busy"},  bus.cmt_rdy, 0);
    check({tag, ".redir_early"}, bus.redir_vld, 0);
    tick();
    check({tag, ".redir_vld"}, bus.redir_vld, 1);
    check({tag, ".redir_pc"},  bus.redir_pc, exp_redir);
    check({tag, ".trap_off"},  bus.trap_ena, 0);
    check({tag, ".in_retr2"},  bus.in_retr, 0);
    tick();
    check({tag, ".redir_drop"}, bus.redir_vld, 0);
    check({tag, ".rdy_post"},   bus.cmt_rdy, 1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 5'b0);
    bus.lsu_busy        = 1'b0;
    bus.csr_mstatus_mie = 1'b0;
    bus.csr_mie         = 3'b000;
    bus.csr_mip         = 3'b000;
    bus.csr_mtvec       = 32'h0000_0800;
    bus.csr_mepc        = 32'h0;
    bus.redir_rdy       = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst.cmt_rdy",   bus.cmt_rdy, 0);
    check("rst.trap_ena",  bus.trap_ena, 0);
    check("rst.redir_vld", bus.redir_vld, 0);
    check("rst.in_retr",   bus.in_retr, 0);
    check("rst.flush",     bus.flush_req, 0);
    rst = 1'b0;
    tick();
    check("post_rst.cmt_rdy", bus.cmt_rdy, 1);

    // ECALL, direct mtvec
    run_trap("ecall", 32'h0000_0100, 32'h0000_0073, 5'b00010,
             32'h0000_000B, 32'h0, 32'h0000_0800);

    // External interrupt on a plain instruction, vectored mtvec
    bus.csr_mstatus_mie = 1'b1;
    bus.csr_mie   = 3'b100;
    bus.csr_mip   = 3'b100;
    bus.csr_mtvec = 32'h0000_1001;
    run_trap("mei", 32'h0000_0200, 32'h0000_0013, 5'b00000,
             32'h8000_000B, 32'h0, 32'h0000_102C);

    // MTI and MSI both pending: MSI wins; direct mtvec
    bus.csr_mie   = 3'b011;
    bus.csr_mip   = 3'b011;
    bus.csr_mtvec = 32'h0000_0800;
    run_trap("msi", 32'h0000_0300, 32'h0000_0013, 5'b00000,
             32'h8000_0003, 32'h0, 32'h0000_0800);

    // Same pending set with mstatus.MIE clear: ordinary retire
    bus.csr_mstatus_mie = 1'b0;
    drive(1'b1, 32'h0000_0304, 32'h0000_0013, 5'b00000);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'b0);
    check("nomie.in_retr",  bus.in_retr, 1);
    check("nomie.trap_ena", bus.trap_ena, 0);
    check("nomie.flush",    bus.flush_req, 0);
    check("nomie.cmt_rdy",  bus.cmt_rdy, 1);
    tick();
    check("nomie.in_retr_off", bus.in_retr, 0);
    check("nomie.redir_vld",   bus.redir_vld, 0);
    bus.csr_mie = 3'b000;
    bus.csr_mip = 3'b000;

    // Misaligned beats ECALL; tval is the bad PC
    run_trap("misalgn", 32'h0000_0702, 32'h0000_0073, 5'b10010,
             32'h0000_0000, 32'h0000_0702, 32'h0000_0800);

    // EBREAK beats ECALL; tval is the PC
    run_trap("ebreak", 32'h0000_0704, 32'h0010_0073, 5'b00110,
             32'h0000_0003, 32'h0000_0704, 32'h0000_0800);

    // MRET with the LSU busy for the accept cycle plus two more: three DRAIN cycles
    bus.csr_mepc = 32'h0000_0345;
    bus.lsu_busy = 1'b1;
    drive(1'b1, 32'h0000_0500, 32'h3020_0073, 5'b00001);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'b0);
    check("mret.flush",     bus.flush_req, 1);
    check("mret.drain1",    bus.mret_ena, 0);
    check("mret.in_retr_d", bus.in_retr, 0);
    tick();
    check("mret.drain2", bus.mret_ena, 0);
    tick();
    check("mret.drain3", bus.mret_ena, 0);
    check("mret.no_redir_d", bus.redir_vld, 0);
    bus.lsu_busy = 1'b0;
    tick();
    check("mret.mret_ena",  bus.mret_ena, 1);
    check("mret.in_retr",   bus.in_retr, 1);
    check("mret.trap_ena",  bus.trap_ena, 0);
    check("mret.cause_wen", bus.cause_wen, 0);
    check("mret.tval_wen",  bus.tval_wen, 0);
    check("mret.epc_en",    bus.epc_en, 0);
    tick();
    check("mret.redir_vld", bus.redir_vld, 1);
    check("mret.redir_pc",  bus.redir_pc, 32'h0000_0344);
    check("mret.in_retr_off", bus.in_retr, 0);
    tick();
    check("mret.idle", bus.cmt_rdy, 1);

    // Illegal MRET: exception wins; exceptions ignore vectored mode; fetch stalls 4 cycles
    bus.csr_mtvec = 32'h0000_1001;
    bus.redir_rdy = 1'b0;
    drive(1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 5'b01001);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'b0);
    check("illm.cause",    bus.cause_dat, 32'h0000_0002);
    check("illm.tval",     bus.tval_dat, 32'hDEAD_BEEF);
    check("illm.mret_ena", bus.mret_ena, 0);
    check("illm.trap_ena", bus.trap_ena, 1);
    check("illm.in_retr",  bus.in_retr, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("illm.hold%0d.vld", i), bus.redir_vld, 1);
      check($sformatf("illm.hold%0d.pc", i),  bus.redir_pc, 32'h0000_1000);
      check($sformatf("illm.hold%0d.rdy", i), bus.cmt_rdy, 0);
      tick();
    end
    bus.redir_rdy = 1'b1;
    check("illm.vld_at_rdy", bus.redir_vld, 1);
    tick();
    check("illm.released", bus.redir_vld, 0);
    check("illm.cmt_rdy",  bus.cmt_rdy, 1);

    // Reset while draining aborts the trap
    bus.csr_mtvec = 32'h0000_0800;
    bus.lsu_busy  = 1'b1;
    drive(1'b1, 32'h0000_0600, 32'h0000_0073, 5'b00010);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'b0);
    check("rstd.flush",    bus.flush_req, 1);
    check("rstd.trap_ena", bus.trap_ena, 0);
    rst = 1'b1;
    tick();
    check("rstd.trap_ena2",  bus.trap_ena, 0);
    check("rstd.redir_vld",  bus.redir_vld, 0);
    check("rstd.flush2",     bus.flush_req, 0);
    check("rstd.epc_en",     bus.epc_en, 0);
    rst = 1'b0;
    bus.lsu_busy = 1'b0;
    tick();
    check("rstd.trap_late", bus.trap_ena, 0);
    check("rstd.redir_late", bus.redir_vld, 0);
    run_trap("ecall2", 32'h0000_0610, 32'h0000_0073, 5'b00010,
             32'h0000_000B, 32'h0, 32'h0000_0800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
